packet_input_arbiter: RTL
=========================

# packet_input_arbiter

Five-input, packet-granular round-robin arbiter that merges the per-port AXI4-Stream receive streams (10G MACs and DMA) into the single stream consumed by `output_port_lookup`. Whole packets are forwarded without interleaving. Each packet's tuser sideband is passed through unchanged. A one-entry registered output stage isolates the lookup stage's tready from the input mux.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 64: tdata width.
- C_AXIS_TUSER_WIDTH, 128: tuser width. [15:0] is the length, [23:16] is the one-hot source port, [31:24] is the one-hot destination. The source fills these fields; this block does not modify them.
- NUM_PORTS, 5: number of slave ports. Fixed at 5; ports are flattened.

Ports:
- axi_aclk  in  1  the single clock. One clock; reset is asynchronous and active-low.
- axi_resetn  in  1  asynchronous, active-low reset.
- s_axis_N_tdata  in  C_AXIS_DATA_WIDTH  input data, N = 0..4.
- s_axis_N_tstrb  in  C_AXIS_DATA_WIDTH/8  byte strobes.
- s_axis_N_tuser  in  C_AXIS_TUSER_WIDTH  sideband. Sampled on every beat and forwarded.
- s_axis_N_tvalid  in  1  input word valid.
- s_axis_N_tready  out  1  input word accepted.
- s_axis_N_tlast  in  1  last word of the packet.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged data.
- m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  merged strobes.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  merged sideband.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  output word accepted by the downstream stage.
- m_axis_tlast  out  1  last word of the output packet.

## Operation
- The FSM has two states, IDLE and PKT. There is also a round-robin pointer `rr_ptr` in the range 0..4, and a registered `grant` in the range 0..4.
- IDLE: scan tvalid starting at rr_ptr and moving upward, wrapping modulo 5. The first asserted port is latched into `grant`, and the FSM goes to PKT on the next edge. If no input is valid, the FSM stays in IDLE. All s_tready are 0 in IDLE.
- PKT: the granted port's tready equals `out_free`, where `out_free = !m_axis_tvalid || m_axis_tready`. All other ports' tready are 0.
- A beat is accepted on the granted port when its tvalid and tready are both high. On acceptance the output register loads tdata, tstrb, tuser and tlast, and sets m_axis_tvalid.
- When the output register is not reloaded and m_axis_tready is high, m_axis_tvalid clears.
- When a tlast beat is accepted, rr_ptr becomes (grant+1) mod 5 and the FSM goes to IDLE. There is no wait for the output to drain.
- Packets are never interleaved. Beats are forwarded in order with no drops, duplication or modification.
- A source that drops tvalid mid-packet stalls the arbiter. The arbiter holds its grant and does not time out.
- Reset values: state=IDLE, rr_ptr=0, grant=0, m_axis_tvalid=0, m_axis_tdata/tstrb/tuser/tlast=0, all s_axis_N_tready=0.
- Reset asserted mid-packet: all outputs clear asynchronously and any in-flight word is lost. After release, the arbiter starts in IDLE with rr_ptr=0. Any tail of the interrupted packet is then treated as a new packet.
- Simultaneous events: a tlast acceptance and a new valid on another port in the same cycle are handled in order. The new request is evaluated in the following IDLE cycle.

## Timing
- Latency from input accept to m_axis_tvalid is 1 cycle.
- Throughput is 1 word per cycle within a packet while m_axis_tready=1.
- Each packet costs exactly 1 IDLE arbitration cycle. Back-to-back packets therefore show one bubble.
- The output register holds stable while m_axis_tvalid=1 and m_axis_tready=0, per AXI4-Stream.
- No s_tready depends combinationally on any s_tvalid. s_tready depends combinationally only on m_axis_tready and registered state.
- With all ports continuously valid, fairness is strict rotation 0,1,2,3,4,0,…

## Structure
- Shared package: the FSM state encoding (IDLE=0, PKT=1), NUM_PORTS=5, and the tuser field offsets (LEN 15:0, SRC 23:16, DST 31:24).
- Natural sub-module: `rr_pick5`. It is combinational. Inputs are a 5-bit request vector and rr_ptr; outputs are the grant index and an any-request flag.

## Test plan
- Single port 2 sends one 10-word packet with tuser=32'h0004_0040 and m_axis_tready held at 1 → 10 output beats, the first one cycle after the first accept. tuser and data match the input, and tlast is on beat 10 only.
- Ports 0..4 all continuously valid, each sending 4-word packets → output order is 0,1,2,3,4,0. Packets do not interleave. Exactly one bubble appears between packets.
- Port 1 mid-packet while m_axis_tready toggles 1,0,0,1 → the output word stays stable during the stall. No word is lost or duplicated, and s_axis_1_tready follows out_free.
- Port 3 granted and port 0 raising tvalid during the packet → port 0 is served only after port 3's tlast. rr_ptr becomes 4 and then 1.
- axi_resetn pulsed low mid-packet on port 4 → m_axis_tvalid and all tready drop immediately. After release, a new packet on port 0 is forwarded correctly.
- Port 2 with a 1-word packet (tlast on the first beat) → a single output beat with tlast=1, and the FSM returns to IDLE the next cycle.

Source files
------------

// File: rtl/packet_input_arbiter_pkg.sv
// Shared definitions for the five-port packet input arbiter: FSM encoding,
// port count and the tuser sideband field layout.
package packet_input_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam int NUM_PORTS = 5;

  localparam int TUSER_LEN_LO = 0;
  localparam int TUSER_LEN_HI = 15;
  localparam int TUSER_SRC_LO = 16;
  localparam int TUSER_SRC_HI = 23;
  localparam int TUSER_DST_LO = 24;
  localparam int TUSER_DST_HI = 31;

  // Next port index, wrapping modulo NUM_PORTS.
  function automatic logic [2:0] port_inc(input logic [2:0] p);
    return (p == 3'(NUM_PORTS - 1)) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/packet_input_arbiter_rr_pick5.sv
// Combinational round-robin picker: first asserted request at or above
// rr_ptr, scanning upward and wrapping over the five ports.
module packet_input_arbiter_rr_pick5
  import packet_input_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [2:0]           rr_ptr,
  output logic [2:0]           grant_idx,
  output logic                 any_req
);

  logic [2:0] idx;

  always_comb begin
    grant_idx = rr_ptr;
    any_req   = 1'b0;
    idx       = rr_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!any_req && req[idx]) begin
        grant_idx = idx;
        any_req   = 1'b1;
      end
      idx = port_inc(idx);
    end
  end

endmodule

// File: rtl/packet_input_arbiter.sv
// Packet-granular round-robin merge of five AXI4-Stream inputs into one
// stream, with a single registered output stage.
module packet_input_arbiter
  import packet_input_arbiter_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 5
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_0_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_0_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_0_tuser,
  input  logic                            s_axis_0_tvalid,
  output logic                            s_axis_0_tready,
  input  logic                            s_axis_0_tlast,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_1_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_1_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_1_tuser,
  input  logic                            s_axis_1_tvalid,
  output logic                            s_axis_1_tready,
  input  logic                            s_axis_1_tlast,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_2_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_2_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_2_tuser,
  input  logic                            s_axis_2_tvalid,
  output logic                            s_axis_2_tready,
  input  logic                            s_axis_2_tlast,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_3_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_3_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_3_tuser,
  input  logic                            s_axis_3_tvalid,
  output logic                            s_axis_3_tready,
  input  logic                            s_axis_3_tlast,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_4_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_4_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_4_tuser,
  input  logic                            s_axis_4_tvalid,
  output logic                            s_axis_4_tready,
  input  logic                            s_axis_4_tlast,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS-1:0]            in_last;
  logic [NUM_PORTS-1:0]            in_ready;
  logic [C_AXIS_DATA_WIDTH-1:0]    in_data [NUM_PORTS];
  logic [C_AXIS_DATA_WIDTH/8-1:0]  in_strb [NUM_PORTS];
  logic [C_AXIS_TUSER_WIDTH-1:0]   in_user [NUM_PORTS];

  assign in_valid = {s_axis_4_tvalid, s_axis_3_tvalid, s_axis_2_tvalid,
                     s_axis_1_tvalid, s_axis_0_tvalid};
  assign in_last  = {s_axis_4_tlast, s_axis_3_tlast, s_axis_2_tlast,
                     s_axis_1_tlast, s_axis_0_tlast};

  assign in_data[0] = s_axis_0_tdata;
  assign in_data[1] = s_axis_1_tdata;
  assign in_data[2] = s_axis_2_tdata;
  assign in_data[3] = s_axis_3_tdata;
  assign in_data[4] = s_axis_4_tdata;
  assign in_strb[0] = s_axis_0_tstrb;
  assign in_strb[1] = s_axis_1_tstrb;
  assign in_strb[2] = s_axis_2_tstrb;
  assign in_strb[3] = s_axis_3_tstrb;
  assign in_strb[4] = s_axis_4_tstrb;
  assign in_user[0] = s_axis_0_tuser;
  assign in_user[1] = s_axis_1_tuser;
  assign in_user[2] = s_axis_2_tuser;
  assign in_user[3] = s_axis_3_tuser;
  assign in_user[4] = s_axis_4_tuser;

  assign s_axis_0_tready = in_ready[0];
  assign s_axis_1_tready = in_ready[1];
  assign s_axis_2_tready = in_ready[2];
  assign s_axis_3_tready = in_ready[3];
  assign s_axis_4_tready = in_ready[4];

  state_t     state, state_nxt;
  logic [2:0] rr_ptr, rr_ptr_nxt;
  logic [2:0] grant, grant_nxt;
  logic [2:0] pick_idx;
  logic       any_req;
  logic       out_free;
  logic       accept;

  packet_input_arbiter_rr_pick5 u_pick (
    .req       (in_valid),
    .rr_ptr    (rr_ptr),
    .grant_idx (pick_idx),
    .any_req   (any_req)
  );

  // Ready never looks at any tvalid, only at registered state and m_axis_tready.
  assign out_free = !m_axis_tvalid || m_axis_tready;

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    in_ready   = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt = pick_idx;
          state_nxt = PKT;
        end
      end
      PKT: begin
        in_ready[grant] = out_free;
        accept          = in_valid[grant] && out_free;
        if (accept && in_last[grant]) begin
          rr_ptr_nxt = port_inc(grant);
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state  <= IDLE;
      rr_ptr <= 3'd0;
      grant  <= 3'd0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      grant  <= grant_nxt;
    end
  end

  // Output stage: one-entry register between the input mux and the lookup stage
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= in_data[grant];
      m_axis_tstrb  <= in_strb[grant];
      m_axis_tuser  <= in_user[grant];
      m_axis_tlast  <= in_last[grant];
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
